wptr_full_ctrl: RTL and testbench
=================================

# wptr_full_ctrl

Write-domain pointer and full-flag controller of the asynchronous FIFO. It consumes the Gray-coded read pointer already synchronized into the write clock domain (`rptr_sync`). It maintains the binary and Gray write pointers, drives the RAM write address, and produces registered full, almost-full, fill-level and sticky-overflow status. Its `wptr` output feeds the write-to-read synchronizer.

## Interface
- `ptr_width`, default 9: address width; FIFO depth = 2**ptr_width; pointers are ptr_width+1 bits.
- `AF_MARGIN`, default 4: `walmost_full` asserts when fill level >= depth − AF_MARGIN; legal range 1..depth−1.

Ports (clock and reset first):
- `wclk` input 1: write clock; the block's only clock.
- `w_rst_n` input 1: reset, asynchronous, active-low.
- `winc` input 1: write request.
- `wovf_clr` input 1: clears `woverflow`.
- `rptr_sync` input ptr_width+1: Gray read pointer, already synchronized to `wclk`.
- `waddr` output ptr_width: RAM write address = low ptr_width bits of the binary write pointer.
- `wen` output 1: RAM write enable = `winc && !wfull`; combinational.
- `wptr` output ptr_width+1: registered Gray write pointer, sent to the read domain.
- `wfull` output 1: registered full flag.
- `walmost_full` output 1: registered almost-full flag.
- `wlevel` output ptr_width+1: registered fill level, 0..depth.
- `woverflow` output 1: sticky flag; set by a write attempted while full.

## Operation
- Write acceptance: a write is accepted on a `wclk` edge when `winc && !wfull`. An accepted write advances `wbin` by 1, modulo 2**(ptr_width+1). A write attempted while full is dropped: no pointer change, no RAM write.
- Next pointers:
  - `wbin_next` = `wbin` + (`winc && !wfull`).
  - `wgray_next` = `wbin_next` ^ (`wbin_next` >> 1).
- Full:
  - `wfull_next` = (`wgray_next` == {~`rptr_sync`[ptr_width:ptr_width−1], `rptr_sync`[ptr_width−2:0]}).
- Level:
  - `rbin_s` = Gray-to-binary of `rptr_sync`.
  - `wlevel_next` = `wbin_next` − `rbin_s`, truncated to ptr_width+1 bits. Wrap-around is handled by modular subtraction.
  - `walmost_full_next` = (`wlevel_next` >= depth − AF_MARGIN).
- Overflow:
  - `woverflow` <= 1 when `winc && wfull`.
  - Otherwise it is cleared to 0 when `wovf_clr`.
  - Set wins when set and clear occur in the same cycle.
- Reset (asserted at any time, including mid-burst): immediately clears `wbin`, `wptr`, `waddr`, `wfull`, `walmost_full`, `wlevel` and `woverflow` to 0. `wen` follows to 0 because `wfull` = 0 only gates; it stays low while `winc` = 0.
- `rptr_sync` is a single-bit-change Gray value. No consistency check is performed on it.

## Timing
- Latency of an accepted write: on the same edge that captures it, `wptr`, `waddr`, `wlevel`, `wfull` and `walmost_full` all reflect the new pointer.
- Full assertion is pessimistic-safe: `wfull` rises on the edge of the write that fills the FIFO. A `winc` in the next cycle is rejected.
- Full deassertion: `wfull`, `wlevel` and `walmost_full` update one `wclk` edge after `rptr_sync` changes. Total read-to-write visibility is therefore the 2-cycle synchronizer plus 1 cycle.
- Simultaneous write and `rptr_sync` advance while not full: the level is unchanged, and the flags are recomputed from both new values.
- Pointer wrap: `wbin` goes from 2**(ptr_width+1)−1 to 0. The Gray MSB toggles, and the full compare stays correct.

## Structure
- Shared package `fifo_pkg`:
  - `bin2gray` and `gray2bin` functions, parameterized by width.
  - Typedefs for the ptr_width+1 pointer and the ptr_width address.
  - Depth constant derived from ptr_width.
- No sub-module: the block is a single module of counter and flag registers plus package functions.

## Test plan
All scenarios use ptr_width=4 (depth 16) and AF_MARGIN=4.
- Reset: drive `w_rst_n`=0 mid-cycle → all outputs read 0 immediately, without a clock edge.
- Fill: hold `rptr_sync`=0 and issue 16 consecutive `winc` writes → `wlevel` counts 1..16; `walmost_full` rises on write 12; `wfull` rises on write 16; `wptr`=5'b11000.
- Overflow: while full, pulse `winc` once → pointer unchanged, `wen`=0, `woverflow`=1. Then pulse `wovf_clr` → `woverflow`=0. Then `winc` and `wovf_clr` together while full → `woverflow` stays 1.
- Drain: from full, step `rptr_sync` through Gray 1, 3, 2 → one cycle after each step, `wlevel` = 15, 14, 13; `wfull` falls one cycle after the first step; `walmost_full` falls when `wlevel` = 11.
- Wrap: stream 40 writes with `rptr_sync` tracking 2 writes behind → `wfull` never asserts; `wlevel` stays at 2; `wbin` wraps past 31 with a correct `waddr` sequence.
- Simultaneous events: write while `rptr_sync` advances at level 8 → `wlevel` stays 8 and `wptr` advances by one Gray step.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion, default pointer types and depth.
package fifo_pkg;

    localparam int PTR_WIDTH_DEFAULT = 9;
    localparam int DEPTH_DEFAULT     = 1 << PTR_WIDTH_DEFAULT;

    typedef logic [PTR_WIDTH_DEFAULT:0]   ptr_t;
    typedef logic [PTR_WIDTH_DEFAULT-1:0] addr_t;

    function automatic int fifo_depth(input int ptr_width);
        return 1 << ptr_width;
    endfunction

    // Both conversions work on zero-extended values of any width up to 32 bits.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and full/almost-full/level/overflow controller of the async FIFO.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ptr_width = 9,
    parameter int AF_MARGIN = 4
) (
    input  logic                 wclk,
    input  logic                 w_rst_n,
    input  logic                 winc,
    input  logic                 wovf_clr,
    input  logic [ptr_width:0]   rptr_sync,
    output logic [ptr_width-1:0] waddr,
    output logic                 wen,
    output logic [ptr_width:0]   wptr,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [ptr_width:0]   wlevel,
    output logic                 woverflow
);

    localparam int PW1   = ptr_width + 1;
    localparam int DEPTH = fifo_depth(ptr_width);
    localparam logic [ptr_width:0] AF_THRESH = PW1'(DEPTH - AF_MARGIN);

    logic [ptr_width:0] wbin;
    logic [ptr_width:0] wbin_next;
    logic [ptr_width:0] wgray_next;
    logic [ptr_width:0] rbin_s;
    logic [ptr_width:0] rptr_full_cmp;
    logic [ptr_width:0] wlevel_next;
    logic               wfull_next;
    logic               walmost_full_next;

    assign wen        = winc && !wfull;
    assign wbin_next  = wbin + PW1'(wen);
    assign wgray_next = PW1'(bin2gray(32'(wbin_next)));
    assign rbin_s     = PW1'(gray2bin(32'(rptr_sync)));

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign rptr_full_cmp     = {~rptr_sync[ptr_width:ptr_width-1], rptr_sync[ptr_width-2:0]};
    assign wfull_next        = (wgray_next == rptr_full_cmp);
    assign wlevel_next       = wbin_next - rbin_s;
    assign walmost_full_next = (wlevel_next >= AF_THRESH);

    assign waddr = wbin[ptr_width-1:0];

    always_ff @(posedge wclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= wfull_next;
            walmost_full <= walmost_full_next;
            wlevel       <= wlevel_next;
        end
    end

    // A dropped write re-arms the flag even if software clears it in the same cycle.
    always_ff @(posedge wclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            woverflow <= 1'b0;
        end else if (winc && wfull) begin
            woverflow <= 1'b1;
        end else if (wovf_clr) begin
            woverflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed table-driven bench for wptr_full_ctrl at ptr_width=4, AF_MARGIN=4.
module tb_wptr_full_ctrl;

    localparam int PW = 4;

    logic          wclk;
    logic          w_rst_n;
    logic          winc;
    logic          wovf_clr;
    logic [PW:0]   rptr_sync;
    logic [PW-1:0] waddr;
    logic          wen;
    logic [PW:0]   wptr;
    logic          wfull;
    logic          walmost_full;
    logic [PW:0]   wlevel;
    logic          woverflow;

    int compared;
    int mismatched;

    typedef struct {
        logic        winc;
        logic        clr;
        logic [PW:0] rptr;
        logic        exp_wen;
        logic [PW:0] exp_level;
        logic        exp_full;
        logic        exp_af;
        logic [PW:0] exp_wptr;
        logic        exp_ovf;
        logic [3:0]  exp_addr;
    } vec_t;

    vec_t vecs[$];

    wptr_full_ctrl #(.ptr_width(PW), .AF_MARGIN(4)) dut (
        .wclk(wclk),
        .w_rst_n(w_rst_n),
        .winc(winc),
        .wovf_clr(wovf_clr),
        .rptr_sync(rptr_sync),
        .waddr(waddr),
        .wen(wen),
        .wptr(wptr),
        .wfull(wfull),
        .walmost_full(walmost_full),
        .wlevel(wlevel),
        .woverflow(woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [PW:0] toGray(input logic [PW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic addVec(input logic wi, input logic cl, input logic [PW:0] rp, input logic we,
                          input logic [PW:0] lv, input logic fu, input logic af,
                          input logic [PW:0] wp, input logic ov, input logic [3:0] ad);
        vec_t v;
        v.winc = wi; v.clr = cl; v.rptr = rp; v.exp_wen = we; v.exp_level = lv;
        v.exp_full = fu; v.exp_af = af; v.exp_wptr = wp; v.exp_ovf = ov; v.exp_addr = ad;
        vecs.push_back(v);
    endtask

    // Drive on the falling edge, check wen combinationally, then check registers after the rising edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        @(negedge wclk);
        winc = v.winc;
        wovf_clr = v.clr;
        rptr_sync = v.rptr;
        #1;
        tag = $sformatf("v%0d", idx);
        checkOutput({tag, ".wen"}, 32'(wen), 32'(v.exp_wen));
        @(posedge wclk);
        #1;
        checkOutput({tag, ".wlevel"}, 32'(wlevel), 32'(v.exp_level));
        checkOutput({tag, ".wfull"}, 32'(wfull), 32'(v.exp_full));
        checkOutput({tag, ".walmost_full"}, 32'(walmost_full), 32'(v.exp_af));
        checkOutput({tag, ".wptr"}, 32'(wptr), 32'(v.exp_wptr));
        checkOutput({tag, ".woverflow"}, 32'(woverflow), 32'(v.exp_ovf));
        checkOutput({tag, ".waddr"}, 32'(waddr), 32'(v.exp_addr));
    endtask

    task automatic doReset();
        @(negedge wclk);
        winc = 1'b0;
        wovf_clr = 1'b0;
        rptr_sync = '0;
        w_rst_n = 1'b0;
        @(negedge wclk);
        w_rst_n = 1'b1;
    endtask

    initial begin
        logic [PW:0] mbin;
        compared = 0;
        mismatched = 0;
        winc = 1'b0;
        wovf_clr = 1'b0;
        rptr_sync = '0;
        w_rst_n = 1'b0;
        #12;
        checkOutput("reset.wptr", 32'(wptr), 32'h0);
        checkOutput("reset.wlevel", 32'(wlevel), 32'h0);
        w_rst_n = 1'b1;

        // Fill: gray(k) for k=1..16 written out by hand.
        addVec(1,0,5'd0,1,5'd1 ,0,0,5'b00001,0,4'd1);
        addVec(1,0,5'd0,1,5'd2 ,0,0,5'b00011,0,4'd2);
        addVec(1,0,5'd0,1,5'd3 ,0,0,5'b00010,0,4'd3);
        addVec(1,0,5'd0,1,5'd4 ,0,0,5'b00110,0,4'd4);
        addVec(1,0,5'd0,1,5'd5 ,0,0,5'b00111,0,4'd5);
        addVec(1,0,5'd0,1,5'd6 ,0,0,5'b00101,0,4'd6);
        addVec(1,0,5'd0,1,5'd7 ,0,0,5'b00100,0,4'd7);
        addVec(1,0,5'd0,1,5'd8 ,0,0,5'b01100,0,4'd8);
        addVec(1,0,5'd0,1,5'd9 ,0,0,5'b01101,0,4'd9);
        addVec(1,0,5'd0,1,5'd10,0,0,5'b01111,0,4'd10);
        addVec(1,0,5'd0,1,5'd11,0,0,5'b01110,0,4'd11);
        addVec(1,0,5'd0,1,5'd12,0,1,5'b01010,0,4'd12);
        addVec(1,0,5'd0,1,5'd13,0,1,5'b01011,0,4'd13);
        addVec(1,0,5'd0,1,5'd14,0,1,5'b01001,0,4'd14);
        addVec(1,0,5'd0,1,5'd15,0,1,5'b01000,0,4'd15);
        addVec(1,0,5'd0,1,5'd16,1,1,5'b11000,0,4'd0);
        // Overflow: dropped write, clear, set-beats-clear, clear again.
        addVec(1,0,5'd0,0,5'd16,1,1,5'b11000,1,4'd0);
        addVec(0,1,5'd0,0,5'd16,1,1,5'b11000,0,4'd0);
        addVec(1,1,5'd0,0,5'd16,1,1,5'b11000,1,4'd0);
        addVec(0,1,5'd0,0,5'd16,1,1,5'b11000,0,4'd0);
        // Drain: read pointer Gray 1,3,2,6,7 = binary 1..5.
        addVec(0,0,5'd1,0,5'd15,0,1,5'b11000,0,4'd0);
        addVec(0,0,5'd3,0,5'd14,0,1,5'b11000,0,4'd0);
        addVec(0,0,5'd2,0,5'd13,0,1,5'b11000,0,4'd0);
        addVec(0,0,5'd6,0,5'd12,0,1,5'b11000,0,4'd0);
        addVec(0,0,5'd7,0,5'd11,0,0,5'b11000,0,4'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Mid-cycle asynchronous reset from a non-zero state.
        @(negedge wclk);
        rptr_sync = '0;
        @(posedge wclk);
        #1;
        winc = 1'b1;
        @(posedge wclk);
        #2;
        winc = 1'b0;
        w_rst_n = 1'b0;
        #1;
        checkOutput("async_rst.wptr", 32'(wptr), 32'h0);
        checkOutput("async_rst.waddr", 32'(waddr), 32'h0);
        checkOutput("async_rst.wfull", 32'(wfull), 32'h0);
        checkOutput("async_rst.walmost_full", 32'(walmost_full), 32'h0);
        checkOutput("async_rst.wlevel", 32'(wlevel), 32'h0);
        checkOutput("async_rst.woverflow", 32'(woverflow), 32'h0);
        checkOutput("async_rst.wen", 32'(wen), 32'h0);
        @(negedge wclk);
        w_rst_n = 1'b1;

        // Wrap: two writes ahead, then 40 writes with the read pointer two behind.
        mbin = '0;
        for (int i = 0; i < 42; i++) begin
            @(negedge wclk);
            winc = 1'b1;
            rptr_sync = (i < 2) ? 5'd0 : toGray(mbin - 5'd1);
            mbin = mbin + 5'd1;
            @(posedge wclk);
            #1;
            if (i >= 2) begin
                checkOutput($sformatf("wrap%0d.wlevel", i), 32'(wlevel), 32'd2);
                checkOutput($sformatf("wrap%0d.wfull", i), 32'(wfull), 32'd0);
                checkOutput($sformatf("wrap%0d.waddr", i), 32'(waddr), 32'(mbin[3:0]));
                checkOutput($sformatf("wrap%0d.wptr", i), 32'(wptr), 32'(toGray(mbin)));
            end
        end

        // Simultaneous write and read advance at level 8.
        doReset();
        for (int i = 0; i < 8; i++) begin
            @(negedge wclk);
            winc = 1'b1;
            rptr_sync = '0;
        end
        @(negedge wclk);
        checkOutput("simul.pre_level", 32'(wlevel), 32'd8);
        winc = 1'b1;
        rptr_sync = 5'd1;
        @(posedge wclk);
        #1;
        checkOutput("simul.wlevel", 32'(wlevel), 32'd8);
        checkOutput("simul.wptr", 32'(wptr), 32'b01101);
        checkOutput("simul.walmost_full", 32'(walmost_full), 32'd0);
        @(negedge wclk);
        winc = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
